// File: rtl/atctlc2axi500_fifo_pkg.sv
// Shared FIFO helpers: width derivations
// and the wrapping pointer increment.
package atctlc2axi500_fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int lvl_w(input int cap);
    return clog2(cap + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : clog2(depth);
  endfunction

  // Wraps at depth-1, so any depth works,
  // power of two or not.
  function automatic int unsigned ptr_inc(
    input int unsigned p,
    input int unsigned depth
  );
    return (p >= depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/atctlc2axi500_sync_fifo_lvl_if.sv
// Write/read handshake, flush and status
// bundle of the level-reporting sync FIFO.
interface atctlc2axi500_sync_fifo_lvl_if #(
  parameter int WIDTH = 8,
  parameter int LVL_W = 3
);
  logic             flush;
  logic [WIDTH-1:0] wdata;
  logic             wvalid;
  logic             wready;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             rready;
  logic [LVL_W-1:0] level;
  logic             almost_full;
  logic             almost_empty;

  modport master (
    output flush, wdata, wvalid, rready,
    input  wready, rdata, rvalid,
    input  level, almost_full, almost_empty
  );

  modport slave (
    input  flush, wdata, wvalid, rready,
    output wready, rdata, rvalid,
    output level, almost_full, almost_empty
  );
endinterface

// File: rtl/atctlc2axi500_mux_onehot.sv
// AND-OR data selector driven by a
// one-hot select vector.
module atctlc2axi500_mux_onehot #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N-1:0]   sel_i,
  input  logic [N*W-1:0] data_i,
  output logic [W-1:0]   data_o
);

  // OR together every input gated by its select bit
  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      data_o = data_o | (data_i[i*W +: W] & {W{sel_i[i]}});
    end
  end

endmodule

// File: rtl/atctlc2axi500_sync_fifo_lvl.sv
// Single-clock valid/ready FIFO with level,
// almost flags, flush and optional output reg.
module atctlc2axi500_sync_fifo_lvl
  import atctlc2axi500_fifo_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int WIDTH       = 8,
  parameter int OUT_REG     = 0,
  parameter int AF_LVL      = DEPTH - 1,
  parameter int AE_LVL      = 1,
  parameter int RAR_SUPPORT = 0
) (
  input logic clk,
  input logic reset_n,
  atctlc2axi500_sync_fifo_lvl_if.slave bus
);

  localparam int CAP   = DEPTH + OUT_REG;
  localparam int LVL_W = lvl_w(CAP);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be at least 2");
  end
  if (AF_LVL < 1 || AF_LVL > CAP) begin : g_bad_af
    $error("AF_LVL must be in 1..CAP");
  end
  if (AE_LVL < 0 || AE_LVL >= CAP) begin : g_bad_ae
    $error("AE_LVL must be in 0..CAP-1");
  end

  logic             oor_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             wready, rvalid;
  logic             wr_fire, rd_fire;
  logic             pop, ovalid_d;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic [DEPTH-1:0]       rsel;
  logic [WIDTH-1:0]       head;

  assign wready  = (cnt_q != CNT_W'(DEPTH))
                 & ~bus.flush & oor_q;
  assign wr_fire = bus.wvalid & wready;
  assign rd_fire = rvalid & bus.rready;

  // Flatten storage and decode rptr one-hot
  always_comb begin
    rsel     = '0;
    mem_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rsel[i] = (rptr_q == PTR_W'(i));
      mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
    end
  end

  atctlc2axi500_mux_onehot #(
    .N(DEPTH),
    .W(WIDTH)
  ) u_rmux (
    .sel_i (rsel),
    .data_i(mem_flat),
    .data_o(head)
  );

  if (OUT_REG != 0) begin : g_oreg
    logic             ovalid_q;
    logic [WIDTH-1:0] oreg_q;

    // Refill the output stage whenever it
    // is empty or being consumed.
    assign pop = (cnt_q != '0)
               & (~ovalid_q | rd_fire)
               & ~bus.flush;
    assign ovalid_d = ~bus.flush
                    & (pop | (ovalid_q & ~rd_fire));
    assign rvalid    = ovalid_q & ~bus.flush;
    assign bus.rdata = oreg_q;

    // Output-stage valid flag
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ovalid_q <= 1'b0;
      else          ovalid_q <= ovalid_d;
    end

    if (RAR_SUPPORT != 0) begin : g_rar
      // Output data register, reset to zero
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) oreg_q <= '0;
        else if (pop) oreg_q <= head;
      end
    end else begin : g_norar
      // Output data register, no reset
      always_ff @(posedge clk) begin
        if (pop) oreg_q <= head;
      end
    end
  end else begin : g_noreg
    assign pop       = rd_fire;
    assign ovalid_d  = 1'b0;
    assign rvalid    = (cnt_q != '0) & ~bus.flush;
    assign bus.rdata = head;
  end

  // Next-state pointers, count, level, flags
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_fire)
      wptr_d = PTR_W'(ptr_inc(32'(wptr_q),
                              DEPTH));
    if (pop)
      rptr_d = PTR_W'(ptr_inc(32'(rptr_q),
                              DEPTH));
    cnt_d = cnt_q + CNT_W'(wr_fire)
                  - CNT_W'(pop);
    if (bus.flush) begin
      cnt_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
    end
    level_d = LVL_W'(cnt_d) + LVL_W'(ovalid_d);
    af_d    = level_d >= LVL_W'(AF_LVL);
    ae_d    = level_d <= LVL_W'(AE_LVL);
  end

  // Control and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oor_q   <= 1'b0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      af_q    <= (AF_LVL <= 0);
      ae_q    <= 1'b1;
    end else begin
      oor_q   <= 1'b1;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
    end
  end

  if (RAR_SUPPORT != 0) begin : g_mem_rar
    // Storage write, cleared on reset
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++)
          mem_q[i] <= '0;
      end else if (wr_fire) begin
        mem_q[wptr_q] <= bus.wdata;
      end
    end
  end else begin : g_mem_norar
    // Storage write, contents not reset
    always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wptr_q] <= bus.wdata;
    end
  end

  assign bus.wready       = wready;
  assign bus.rvalid       = rvalid;
  assign bus.level        = level_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;

endmodule
